// File: rtl/debounce_pair.sv
// Two-channel synchroniser + debounce filter feeding a 2-input downstream gate.
// Optional registered edge pulses under `DEBOUNCE_EDGE_EN; otherwise the pulse ports are tied 0.

module debounce_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 10,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);
  // Encoding keeps the debounced level in state bit 1, so lvl comes straight off a flop.
  typedef enum logic [1:0] {
    ST_LO     = 2'b00,
    ST_CHK_HI = 2'b01,
    ST_HI     = 2'b11,
    ST_CHK_LO = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any return of s to the settled value restarts filtering from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LO: begin
        cnt_d = '0;
        if (s) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_CHK_HI;
        end
      end
      ST_CHK_HI: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = ST_LO;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        cnt_d = '0;
        if (!s) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_CHK_LO;
        end
      end
      ST_CHK_LO: begin
        if (s) begin
          cnt_d   = '0;
          state_d = ST_HI;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_LO;
      end
    endcase
  end

  always_comb begin
    lvl = state_q[1];
  end

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses register alongside state, so they coincide with the level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <=  state_d[1] & ~state_q[1];
      fall_q <= ~state_d[1] &  state_q[1];
    end
  end
  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

module debounce_pair #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 10,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } lane_out_t;

  logic      [NUM_LANES-1:0] raw_v;
  lane_out_t [NUM_LANES-1:0] lane_o;

  assign raw_v = {b_raw, a_raw};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    debounce_lane #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_v[i]),
      .lvl  (lane_o[i].lvl),
      .rise (lane_o[i].rise),
      .fall (lane_o[i].fall)
    );
  end

  assign a      = lane_o[0].lvl;
  assign a_rise = lane_o[0].rise;
  assign a_fall = lane_o[0].fall;
  assign b      = lane_o[1].lvl;
  assign b_rise = lane_o[1].rise;
  assign b_fall = lane_o[1].fall;

endmodule

// File: tb/tb_debounce_pair.sv
// Scoreboard bench for debounce_pair: stimulus queues expected level changes, a negedge monitor checks them.
module tb_debounce_pair;
  localparam int LAT = 11;

  logic clk = 1'b0;
  logic rst_n, a_raw, b_raw;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  typedef struct {
    int edge_no;
    int ch;
    bit val;
  } ev_t;

  ev_t        sb_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [1:0] mon_prev = 2'b00;
  logic [1:0] mon_cur, exp_r, exp_f;
  ev_t        mon_ev;

  debounce_pair dut (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int e, input int ch, input bit v);
    ev_t ev;
    ev.edge_no = e;
    ev.ch      = ch;
    ev.val     = v;
    sb_q.push_back(ev);
  endtask

  // Monitor: every level change must match the head of the scoreboard.
  always @(negedge clk) begin
    mon_cur = {b, a};
    if (!rst_n) begin
      n_chk++;
      if (mon_cur != 2'b00 || {a_rise, a_fall, b_rise, b_fall} != 4'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got ab=%b pulses=%b, need 00/0000", mon_cur,
                 {a_rise, a_fall, b_rise, b_fall});
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (mon_cur[ch] != mon_prev[ch]) begin
          n_chk++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change: ch%0d -> %0b after edge %0d, none expected",
                     ch, mon_cur[ch], cyc - 1);
          end else begin
            mon_ev = sb_q.pop_front();
            if (mon_ev.edge_no != cyc - 1 || mon_ev.ch != ch || mon_ev.val != mon_cur[ch]) begin
              n_fail++;
              $display("FAIL level_change: got ch%0d=%0b at edge %0d, need ch%0d=%0b at edge %0d",
                       ch, mon_cur[ch], cyc - 1, mon_ev.ch, mon_ev.val, mon_ev.edge_no);
            end
          end
        end
      end
`ifdef DEBOUNCE_EDGE_EN
      exp_r = mon_cur & ~mon_prev;
      exp_f = ~mon_cur & mon_prev;
`else
      exp_r = 2'b00;
      exp_f = 2'b00;
`endif
      n_chk++;
      if ({b_rise, a_rise} != exp_r || {b_fall, a_fall} != exp_f) begin
        n_fail++;
        $display("FAIL pulses: got rise=%b fall=%b after edge %0d, need rise=%b fall=%b",
                 {b_rise, a_rise}, {b_fall, a_fall}, cyc - 1, exp_r, exp_f);
      end
    end
    mon_prev = mon_cur;
  end

  initial begin
    int n;
    rst_n = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;

    // Reset held with both raw inputs high, then release.
    tick(20);
    rst_n = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b1);
    expect_ev(n + LAT, 1, 1'b1);
    tick(20);

    // Asynchronous reset while both outputs are high must clear them without a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a !== 1'b0 || b !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_high: got a=%b b=%b, need 0 0", a, b);
    end
    @(negedge clk);
    a_raw = 1'b0;
    b_raw = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);

    // Clean step on A only.
    a_raw = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b1);
    tick(25);
    a_raw = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b0);
    tick(25);

    // Short glitch is rejected.
    a_raw = 1'b1;
    tick(5);
    a_raw = 1'b0;
    tick(30);

    // Bounce every 3 cycles, then settle high.
    for (int i = 0; i < 10; i++) begin
      a_raw = ~a_raw;
      tick(3);
    end
    a_raw = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b1);
    tick(25);
    a_raw = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b0);
    tick(25);

    // Both channels together; A drops later while B holds.
    a_raw = 1'b1;
    b_raw = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b1);
    expect_ev(n + LAT, 1, 1'b1);
    tick(40);
    a_raw = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      n_chk++;
      if ((a | b) !== 1'b1) begin
        n_fail++;
        $display("FAIL or_output: got y=%b at cycle %0d, need 1", a | b, cyc);
      end
    end
    b_raw = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 1, 1'b0);
    tick(25);

    // Reset mid-count must discard progress; full latency required afterwards.
    a_raw = 1'b1;
    tick(6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_midcount: got a=%b, need 0", a);
    end
    tick(2);
    rst_n = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b1);
    tick(25);
    a_raw = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 0, 1'b0);
    tick(25);

    while (sb_q.size() != 0) begin
      ev_t ev;
      ev = sb_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_change: got no change, need ch%0d=%0b at edge %0d",
               ev.ch, ev.val, ev.edge_no);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
